// File: rtl/uart_protocol.sv
// rtl/uart_protocol.sv - UART with TX/RX word FIFOs, even parity and an oversampled receiver
// Frame on the line: start(0), DATA_SIZE data bits LSB first, even parity, stop(1).

module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             error_write_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset_n) begin
      wptr             <= '0;
      rptr             <= '0;
      count            <= '0;
      error_write_data <= 1'b0;
    end else begin
      error_write_data <= push && full;
      if (do_push) wptr <= (wptr == PW'(DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == PW'(DEPTH - 1)) ? '0 : rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

module uart_protocol #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 8,
  parameter int SYS_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int SAMPLE    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 write_data,
  input  logic                 read_data,
  input  logic [DATA_SIZE-1:0] bus_data_in,
  output logic [DATA_SIZE-1:0] bus_data_out,
  input  logic                 serial_data_in,
  output logic                 serial_data_out,
  output logic [7:0]           TX_status_register,
  output logic [7:0]           RX_status_register
);
  localparam int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE);
  localparam int BW = $clog2(BAUD_DVSR + 1);
  localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
  localparam int IW = $clog2(DATA_SIZE + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

  logic [BW-1:0] baud_cnt;
  logic          baud_tick;

  assign baud_tick = (baud_cnt == BW'(BAUD_DVSR - 1));

  always_ff @(posedge clk) begin
    if (reset_n) baud_cnt <= '0;
    else         baud_cnt <= baud_tick ? '0 : baud_cnt + 1'b1;
  end

  uart_state_t          tx_state, tx_next;
  logic [DATA_SIZE-1:0] tx_shreg, tx_fifo_rdata;
  logic [SW-1:0]        tx_tick_cnt;
  logic [IW-1:0]        tx_bit_idx;
  logic                 tx_parity, tx_pop, tx_empty, tx_full, tx_werr, tx_bit_end;

  uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(SIZE_FIFO)) u_tx_fifo (
    .clk(clk), .reset_n(reset_n), .push(write_data), .pop(tx_pop), .wdata(bus_data_in),
    .rdata(tx_fifo_rdata), .empty(tx_empty), .full(tx_full), .error_write_data(tx_werr)
  );

  assign tx_bit_end = baud_tick && (tx_tick_cnt == SW'(SAMPLE - 1));

  always_ff @(posedge clk) begin
    if (reset_n) tx_state <= IDLE;
    else         tx_state <= tx_next;
  end

  // Leaving STOP straight into START keeps back-to-back frames gapless.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      IDLE:   if (baud_tick && !tx_empty) begin tx_pop = 1'b1; tx_next = START; end
      START:  if (tx_bit_end) tx_next = DATA;
      DATA:   if (tx_bit_end && tx_bit_idx == IW'(DATA_SIZE - 1)) tx_next = PARITY;
      PARITY: if (tx_bit_end) tx_next = STOP;
      STOP: begin
        if (tx_bit_end) begin
          if (!tx_empty) begin tx_pop = 1'b1; tx_next = START; end
          else tx_next = IDLE;
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      tx_shreg        <= '0;
      tx_parity       <= 1'b0;
      tx_tick_cnt     <= '0;
      tx_bit_idx      <= '0;
      serial_data_out <= 1'b1;
    end else begin
      if (tx_pop) begin
        tx_shreg    <= tx_fifo_rdata;
        tx_parity   <= ^tx_fifo_rdata;
        tx_tick_cnt <= '0;
        tx_bit_idx  <= '0;
      end else if (baud_tick && tx_state != IDLE) begin
        tx_tick_cnt <= tx_bit_end ? '0 : tx_tick_cnt + 1'b1;
        if (tx_bit_end && tx_state == DATA) begin
          tx_shreg   <= tx_shreg >> 1;
          tx_bit_idx <= tx_bit_idx + 1'b1;
        end
      end
      case (tx_state)
        START:   serial_data_out <= 1'b0;
        DATA:    serial_data_out <= tx_shreg[0];
        PARITY:  serial_data_out <= tx_parity;
        default: serial_data_out <= 1'b1;
      endcase
    end
  end

  uart_state_t          rx_state, rx_next;
  logic [DATA_SIZE-1:0] rx_shreg, rx_fifo_rdata;
  logic [SW-1:0]        rx_tick_cnt;
  logic [IW-1:0]        rx_bit_idx;
  logic                 rx_s1, rx_s2, rx_prev, rx_parity, rx_push, rx_empty, rx_full, rx_werr;
  logic                 rx_bit_end, rx_half_end;
  logic                 parity_error, stop_error, break_error, overflow_error, read_not_ready;

  uart_fifo #(.WIDTH(DATA_SIZE), .DEPTH(SIZE_FIFO)) u_rx_fifo (
    .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(read_data), .wdata(rx_shreg),
    .rdata(rx_fifo_rdata), .empty(rx_empty), .full(rx_full), .error_write_data(rx_werr)
  );

  assign rx_bit_end  = baud_tick && (rx_tick_cnt == SW'(SAMPLE - 1));
  assign rx_half_end = baud_tick && (rx_tick_cnt == SW'(SAMPLE / 2 - 1));
  assign rx_push     = (rx_state == STOP) && rx_bit_end;

  always_ff @(posedge clk) begin
    if (reset_n) rx_state <= IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      IDLE:    if (rx_prev && !rx_s2) rx_next = START;
      START:   if (rx_half_end) rx_next = rx_s2 ? IDLE : DATA;
      DATA:    if (rx_bit_end && rx_bit_idx == IW'(DATA_SIZE - 1)) rx_next = PARITY;
      PARITY:  if (rx_bit_end) rx_next = STOP;
      STOP:    if (rx_bit_end) rx_next = IDLE;
      default: rx_next = IDLE;
    endcase
  end

  // Two-flop synchroniser; rx_prev gives the falling-edge detector its history.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1; rx_prev <= 1'b1;
    end else begin
      rx_s1 <= serial_data_in; rx_s2 <= rx_s1; rx_prev <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      rx_shreg       <= '0;
      rx_parity      <= 1'b0;
      rx_tick_cnt    <= '0;
      rx_bit_idx     <= '0;
      parity_error   <= 1'b0;
      stop_error     <= 1'b0;
      break_error    <= 1'b0;
      overflow_error <= 1'b0;
      read_not_ready <= 1'b0;
      bus_data_out   <= '0;
    end else begin
      if (rx_state == IDLE) begin
        rx_tick_cnt <= '0;
        rx_bit_idx  <= '0;
      end else if (baud_tick) begin
        rx_tick_cnt <= ((rx_state == START && rx_half_end) || rx_bit_end) ? '0 : rx_tick_cnt + 1'b1;
        if (rx_bit_end) begin
          case (rx_state)
            DATA: begin
              rx_shreg   <= {rx_s2, rx_shreg[DATA_SIZE-1:1]};
              rx_bit_idx <= rx_bit_idx + 1'b1;
            end
            PARITY: rx_parity <= rx_s2;
            STOP: begin
              parity_error <= (^rx_shreg) != rx_parity;
              stop_error   <= !rx_s2;
              break_error  <= (rx_shreg == '0) && !rx_parity && !rx_s2;
            end
            default: ;
          endcase
        end
      end
      if (rx_push) overflow_error <= rx_full;
      read_not_ready <= read_data && rx_empty;
      if (read_data && !rx_empty) bus_data_out <= rx_fifo_rdata;
    end
  end

  assign TX_status_register = {5'b0, tx_empty, tx_full, tx_werr};
  assign RX_status_register = {read_not_ready, overflow_error, stop_error, break_error,
                               parity_error, rx_empty, rx_full, rx_werr};
endmodule

// File: tb/tb_uart_protocol.sv
// tb/tb_uart_protocol.sv - randomized scoreboard bench for uart_protocol
// Runs with a 2-clock baud divider so a frame is 11*32 clocks.

module tb_uart_protocol;
  localparam int DATA_SIZE = 8;
  localparam int SIZE_FIFO = 8;
  localparam int SAMPLE    = 16;
  localparam int BAUD_RATE = 9600;
  localparam int DVSR      = 2;
  localparam int SYS_FREQ  = DVSR * SAMPLE * BAUD_RATE;
  localparam int BT        = DVSR * SAMPLE;
  localparam int FRAME     = BT * (DATA_SIZE + 3);

  logic       clk = 1'b0;
  logic       reset_n, write_data, read_data;
  logic [7:0] bus_data_in, bus_data_out;
  logic       serial_data_in, serial_data_out;
  logic [7:0] tx_status, rx_status;
  logic       loop_en, rx_line, mon_en;
  logic [7:0] last_read;
  logic [7:0] tx_exp[$];
  logic [7:0] rx_exp[$];
  int         tests = 0, fails = 0, rx_err_pulses = 0;

  always #5 clk = ~clk;
  assign serial_data_in = loop_en ? serial_data_out : rx_line;

  uart_protocol #(
    .DATA_SIZE(DATA_SIZE), .SIZE_FIFO(SIZE_FIFO), .SYS_FREQ(SYS_FREQ),
    .BAUD_RATE(BAUD_RATE), .SAMPLE(SAMPLE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .write_data(write_data), .read_data(read_data),
    .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
    .serial_data_in(serial_data_in), .serial_data_out(serial_data_out),
    .TX_status_register(tx_status), .RX_status_register(rx_status)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Decodes every frame on the TX line mid-bit and matches it to the next expected word.
  initial begin : tx_monitor
    logic        prev;
    logic [10:0] frame;
    logic [7:0]  d;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !serial_data_out) begin
        repeat (BT / 2) @(negedge clk);
        frame[0] = serial_data_out;
        for (int i = 1; i < 11; i++) begin
          repeat (BT) @(negedge clk);
          frame[i] = serial_data_out;
        end
        if (tx_exp.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", frame);
        end else begin
          d = tx_exp.pop_front();
          check("tx_frame", {21'b0, frame}, {21'b0, 1'b1, ^d, d, 1'b0});
        end
      end
      prev = serial_data_out;
    end
  end

  // Every read is matched either to the next queued word or to a not-ready response.
  initial begin : rx_monitor
    logic       pend_data, pend_nr;
    logic [7:0] exp_d;
    pend_data = 1'b0;
    pend_nr   = 1'b0;
    exp_d     = '0;
    forever begin
      @(negedge clk);
      if (pend_data) begin
        check("rx_read_data", bus_data_out, exp_d);
        check("rx_ready_flag", rx_status[7], 0);
      end
      if (pend_nr) begin
        check("rx_not_ready", rx_status[7], 1);
        check("rx_hold_data", bus_data_out, last_read);
      end
      pend_data = 1'b0;
      pend_nr   = 1'b0;
      if (rx_status[0]) rx_err_pulses++;
      if (read_data) begin
        if (rx_exp.size() > 0) begin
          exp_d     = rx_exp.pop_front();
          last_read = exp_d;
          pend_data = 1'b1;
        end else begin
          pend_nr = 1'b1;
        end
      end
    end
  end

  task automatic write_word(input logic [7:0] d, input bit accept);
    bus_data_in = d;
    write_data  = 1'b1;
    if (accept) begin
      tx_exp.push_back(d);
      if (loop_en) rx_exp.push_back(d);
    end
    @(posedge clk); #1;
    write_data = 1'b0;
  endtask

  task automatic read_word();
    read_data = 1'b1;
    @(posedge clk); #1;
    read_data = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit flip_par, input bit stop_bit);
    logic [10:0] f;
    f = {stop_bit, (^d) ^ flip_par, d, 1'b0};
    if (rx_exp.size() < SIZE_FIFO) rx_exp.push_back(d);
    for (int i = 0; i < 11; i++) begin
      rx_line = f[i];
      repeat (BT) @(posedge clk);
      #1;
    end
    rx_line = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_drain(input string name);
    int n;
    n = 0;
    while (tx_exp.size() != 0 && n < 12 * FRAME) begin
      @(posedge clk);
      n++;
    end
    #1;
    tests++;
    if (tx_exp.size() != 0) begin
      fails++;
      $display("FAIL %s: got %0d words pending expected 0", name, tx_exp.size());
    end
    repeat (BT) @(posedge clk);
    #1;
  endtask

  initial begin
    int         n;
    logic [7:0] d;
    reset_n = 1'b1; write_data = 1'b0; read_data = 1'b0; bus_data_in = '0;
    loop_en = 1'b0; rx_line = 1'b1; mon_en = 1'b1; last_read = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_status", tx_status, 8'h04);
    check("reset_rx_status", rx_status, 8'h04);
    check("reset_line", serial_data_out, 1);
    check("reset_bus_out", bus_data_out, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;

    write_word(8'hA5, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("tx_empty_after_pop", tx_status, 8'h04);
    @(posedge clk); #1;
    wait_tx_drain("tx_a5_drain");

    loop_en = 1'b1;
    write_word(8'h3C, 1'b1);
    n = 0;
    while (rx_status[2] && n < 2 * FRAME) begin @(negedge clk); n++; end
    check("loop_rx_not_empty", rx_status[2], 0);
    wait_tx_drain("loop_3c_drain");
    check("loop_rx_flags", rx_status[7:3], 0);
    read_word();

    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) write_word(8'($urandom), 1'b1);
      wait_tx_drain("rand_loop_drain");
      check("rand_loop_flags", rx_status[6:3], 0);
      for (int k = 0; k < n; k++) read_word();
      @(negedge clk);
      check("rand_loop_rx_empty", rx_status[2], 1);
      @(posedge clk); #1;
    end

    loop_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      write_word(8'($urandom), i < 9);
      @(negedge clk);
      check("tx_write_error", tx_status[0], (i == 9));
      if (i >= 8) check("tx_full", tx_status[1], 1);
      @(posedge clk); #1;
    end
    wait_tx_drain("tx_full_drain");
    repeat (FRAME) @(posedge clk);
    #1;
    check("tx_idle_after_drain", tx_status, 8'h04);

    send_frame(8'($urandom), 1'b1, 1'b1);
    check("rx_parity_flags", rx_status[6:3], 4'b0001);
    read_word();
    send_frame(8'h00, 1'b0, 1'b0);
    check("rx_break_flags", rx_status[6:3], 4'b0110);
    read_word();
    send_frame(8'($urandom), 1'b0, 1'b1);
    check("rx_clean_flags", rx_status[6:3], 4'b0000);
    read_word();

    repeat (2) @(posedge clk);
    #1;
    read_word();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rx_not_ready_one_cycle", rx_status[7], 0);
    @(posedge clk); #1;

    rx_err_pulses = 0;
    for (int k = 0; k < 9; k++) begin
      send_frame(8'($urandom), 1'b0, 1'b1);
      check("rx_overflow", rx_status[6], (k == 8));
    end
    check("rx_full", rx_status[1], 1);
    check("rx_err_pulses", rx_err_pulses, 1);
    for (int k = 0; k < SIZE_FIFO; k++) read_word();
    send_frame(8'($urandom), 1'b0, 1'b1);
    check("rx_overflow_clear", rx_status[6], 0);
    read_word();
    repeat (2) @(posedge clk);
    #1;

    mon_en  = 1'b0;
    loop_en = 1'b1;
    d = 8'($urandom);
    write_word(d, 1'b0);
    repeat (5 * BT) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    last_read = '0;
    @(negedge clk);
    check("abort_line_high", serial_data_out, 1);
    check("abort_tx_status", tx_status, 8'h04);
    repeat (FRAME) @(posedge clk);
    @(negedge clk);
    check("abort_rx_no_push", rx_status, 8'h04);
    check("abort_bus_out", bus_data_out, 0);
    mon_en = 1'b1;
    repeat (BT) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
